// File: rtl/vram_banked_fill.sv
// Two-bank video RAM with a display read port, a host write port and a fill engine.
// The lower half of the address space maps one-to-one onto the lower bank. The upper
// half repeatedly mirrors a smaller upper bank. A host write always wins the shared
// write port; the fill engine only uses the cycles in which the host is not writing.
module vram_banked_fill #(
    parameter int DATA_W   = 8,
    parameter int LOWER_AW = 12,
    parameter int UPPER_AW = 10,
    parameter int RD_PIPE  = 0,
    localparam int ADDR_W  = LOWER_AW + 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] vramWrAddr,
    input  logic [DATA_W-1:0] vramWrData,
    input  logic              vramWr,
    input  logic [ADDR_W-1:0] vramRdAddr,
    output logic [DATA_W-1:0] vramRdData,
    input  logic              fillStart,
    input  logic [ADDR_W-1:0] fillAddr,
    input  logic [ADDR_W:0]   fillLen,
    input  logic [DATA_W-1:0] fillData,
    output logic              fillBusy,
    output logic              fillDone
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fillState_t;

    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    fillState_t        r_state;
    fillState_t        w_nextState;
    logic              w_fillWe;
    logic [ADDR_W-1:0] r_curAddr;
    logic [DATA_W-1:0] r_val;
    logic [ADDR_W:0]   r_remaining;

    logic              w_wrEn;
    logic [ADDR_W-1:0] w_wrAddr;
    logic [DATA_W-1:0] w_wrData;
    logic              w_lowerWe;
    logic              w_upperWe;

    logic [DATA_W-1:0] r_lowerMem [2**LOWER_AW];
    logic [DATA_W-1:0] r_upperMem [2**UPPER_AW];
    logic [DATA_W-1:0] r_lowerRd;
    logic [DATA_W-1:0] r_upperRd;
    logic              r_rdUpperSel;
    logic [DATA_W-1:0] w_rdMux;

    // Fill sequencer decision: a fill word goes out only when the host leaves the port free.
    // The write is also held off while reset is asserted, so that a reset aborts the fill
    // on the very edge at which it is sampled.
    always_comb begin
        w_nextState = r_state;
        w_fillWe    = 1'b0;
        case (r_state)
            IDLE: begin
                if (fillStart) begin
                    w_nextState = (fillLen == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                w_fillWe = ~vramWr & nrst;
                if (!vramWr && r_remaining == LEN_ONE) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Fill sequencer state register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Fill job registers: the job is latched on an accepted start and advanced once per written word.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_curAddr   <= '0;
            r_val       <= '0;
            r_remaining <= '0;
        end else if (r_state == IDLE && fillStart) begin
            r_curAddr   <= fillAddr;
            r_val       <= fillData;
            r_remaining <= fillLen;
        end else if (w_fillWe) begin
            r_curAddr   <= r_curAddr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
        end
    end

    assign fillBusy = (r_state != IDLE);
    assign fillDone = (r_state == DONE);

    // Shared write port: the host has priority, and the fill engine fills in the gaps.
    assign w_wrEn    = vramWr | w_fillWe;
    assign w_wrAddr  = vramWr ? vramWrAddr : r_curAddr;
    assign w_wrData  = vramWr ? vramWrData : r_val;
    assign w_lowerWe = w_wrEn & ~w_wrAddr[ADDR_W-1];
    assign w_upperWe = w_wrEn &  w_wrAddr[ADDR_W-1];

    // Lower bank: one write port and one registered read-first read port.
    always_ff @(posedge clk) begin
        if (w_lowerWe) begin
            r_lowerMem[w_wrAddr[LOWER_AW-1:0]] <= w_wrData;
        end
        if (!nrst) begin
            r_lowerRd <= '0;
        end else begin
            r_lowerRd <= r_lowerMem[vramRdAddr[LOWER_AW-1:0]];
        end
    end

    // Upper bank: only the low index bits are used, so the upper region mirrors it.
    always_ff @(posedge clk) begin
        if (w_upperWe) begin
            r_upperMem[w_wrAddr[UPPER_AW-1:0]] <= w_wrData;
        end
        if (!nrst) begin
            r_upperRd <= '0;
        end else begin
            r_upperRd <= r_upperMem[vramRdAddr[UPPER_AW-1:0]];
        end
    end

    // The bank-select bit travels alongside the read so that the output mux lines up with the data.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_rdUpperSel <= 1'b0;
        end else begin
            r_rdUpperSel <= vramRdAddr[ADDR_W-1];
        end
    end

    assign w_rdMux = r_rdUpperSel ? r_upperRd : r_lowerRd;

    generate
        if (RD_PIPE != 0) begin : g_rdPipe
            logic [DATA_W-1:0] r_rdPipe;

            // Optional extra output stage to ease timing towards the display fetch logic.
            always_ff @(posedge clk) begin
                if (!nrst) begin
                    r_rdPipe <= '0;
                end else begin
                    r_rdPipe <= w_rdMux;
                end
            end

            assign vramRdData = r_rdPipe;
        end else begin : g_rdDirect
            assign vramRdData = w_rdMux;
        end
    endgenerate

endmodule

// File: tb/tb_vram_banked_fill.sv
// Bench for vram_banked_fill. Two instances share every input: one without the extra
// read stage and one with it. A behavioural model follows the input stream and, on every
// cycle, predicts the read data, busy and done outputs. Directed scenarios add literal
// expectations for memory contents and fill timing.
module tb_vram_banked_fill;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 13;

    logic              clk;
    logic              nrst;
    logic [ADDR_W-1:0] vramWrAddr;
    logic [DATA_W-1:0] vramWrData;
    logic              vramWr;
    logic [ADDR_W-1:0] vramRdAddr;
    logic [DATA_W-1:0] vramRdData;
    logic              fillStart;
    logic [ADDR_W-1:0] fillAddr;
    logic [ADDR_W:0]   fillLen;
    logic [DATA_W-1:0] fillData;
    logic              fillBusy;
    logic              fillDone;
    logic [DATA_W-1:0] rdDataP;
    logic              busyP;
    logic              doneP;

    int vecCount  = 0;
    int missCount = 0;
    bit chkEn     = 0;

    vram_banked_fill #(.DATA_W(8), .LOWER_AW(12), .UPPER_AW(10), .RD_PIPE(0)) dut (
        .clk(clk), .nrst(nrst),
        .vramWrAddr(vramWrAddr), .vramWrData(vramWrData), .vramWr(vramWr),
        .vramRdAddr(vramRdAddr), .vramRdData(vramRdData),
        .fillStart(fillStart), .fillAddr(fillAddr), .fillLen(fillLen), .fillData(fillData),
        .fillBusy(fillBusy), .fillDone(fillDone)
    );

    vram_banked_fill #(.DATA_W(8), .LOWER_AW(12), .UPPER_AW(10), .RD_PIPE(1)) dutPipe (
        .clk(clk), .nrst(nrst),
        .vramWrAddr(vramWrAddr), .vramWrData(vramWrData), .vramWr(vramWr),
        .vramRdAddr(vramRdAddr), .vramRdData(rdDataP),
        .fillStart(fillStart), .fillAddr(fillAddr), .fillLen(fillLen), .fillData(fillData),
        .fillBusy(busyP), .fillDone(doneP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: physical storage is 4096 lower words followed by 1024 upper words.
    logic [7:0]  mMem   [0:5119];
    bit          mKnown [0:5119];
    int          mPhase = 0;
    logic [12:0] mPtr   = '0;
    logic [7:0]  mVal   = '0;
    int          mLeft  = 0;
    logic [7:0]  expRd0 = '0;
    bit          expRd0Known = 0;
    logic [7:0]  expP1  = '0;
    bit          expP1Known = 0;
    bit          expBusy = 0;
    bit          expDone = 0;

    initial begin
        for (int i = 0; i < 5120; i++) begin
            mKnown[i] = 0;
        end
    end

    function automatic int physKey(input logic [12:0] a);
        if (a[12]) begin
            return 4096 + int'(a[9:0]);
        end
        return int'(a[11:0]);
    endfunction

    // Model step: read the old contents first, then apply the write the port grants this cycle.
    always @(posedge clk) begin
        int k;
        if (!nrst) begin
            expP1 = '0;
            expP1Known = 1;
            expRd0 = '0;
            expRd0Known = 1;
        end else begin
            expP1 = expRd0;
            expP1Known = expRd0Known;
            k = physKey(vramRdAddr);
            expRd0 = mMem[k];
            expRd0Known = mKnown[k];
        end
        if (vramWr) begin
            k = physKey(vramWrAddr);
            mMem[k] = vramWrData;
            mKnown[k] = 1;
        end else if (mPhase == 1 && nrst) begin
            k = physKey(mPtr);
            mMem[k] = mVal;
            mKnown[k] = 1;
            mPtr = mPtr + 13'd1;
            mLeft = mLeft - 1;
        end
        if (!nrst) begin
            mPhase = 0;
        end else if (mPhase == 0) begin
            if (fillStart) begin
                mPtr  = fillAddr;
                mVal  = fillData;
                mLeft = int'(fillLen);
                mPhase = (fillLen == 0) ? 2 : 1;
            end
        end else if (mPhase == 1) begin
            if (mLeft == 0) mPhase = 2;
        end else begin
            mPhase = 0;
        end
        expBusy = (mPhase != 0);
        expDone = (mPhase == 2);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, on the falling edge where outputs are stable.
    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("fillBusy", {31'd0, fillBusy}, {31'd0, expBusy});
            checkOutput("fillDone", {31'd0, fillDone}, {31'd0, expDone});
            checkOutput("pipe fillBusy", {31'd0, busyP}, {31'd0, expBusy});
            checkOutput("pipe fillDone", {31'd0, doneP}, {31'd0, expDone});
            if (expRd0Known) checkOutput("vramRdData", {24'd0, vramRdData}, {24'd0, expRd0});
            if (expP1Known)  checkOutput("pipe vramRdData", {24'd0, rdDataP}, {24'd0, expP1});
        end
    end

    task automatic applyStimulus(input logic wr, input logic [12:0] wa, input logic [7:0] wd,
                                 input logic [12:0] ra, input logic fs, input logic [12:0] fa,
                                 input logic [13:0] fl, input logic [7:0] fd);
        @(negedge clk);
        vramWr = wr; vramWrAddr = wa; vramWrData = wd; vramRdAddr = ra;
        fillStart = fs; fillAddr = fa; fillLen = fl; fillData = fd;
    endtask

    task automatic hostWrite(input logic [12:0] a, input logic [7:0] d);
        applyStimulus(1'b1, a, d, 13'd0, 1'b0, 13'd0, 14'd0, 8'd0);
    endtask

    task automatic readCheck(input string name, input logic [12:0] a, input logic [7:0] exp);
        applyStimulus(1'b0, 13'd0, 8'd0, a, 1'b0, 13'd0, 14'd0, 8'd0);
        @(posedge clk);
        #1;
        checkOutput(name, {24'd0, vramRdData}, {24'd0, exp});
    endtask

    task automatic startFill(input logic [12:0] a, input logic [13:0] l, input logic [7:0] d);
        applyStimulus(1'b0, 13'd0, 8'd0, 13'd0, 1'b1, a, l, d);
    endtask

    logic [7:0] rstRd;
    logic       rstBusy;
    logic       rstDone;

    // Follows a started fill cycle by cycle; k counts cycles after the one carrying fillStart.
    task automatic waitFill(input int stallAt, input int stallN, input int injAt, input int rstAt,
                            input int limit, output int doneAt, output int busyCnt);
        doneAt = 0;
        busyCnt = 0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (fillBusy) busyCnt++;
            if (fillDone && doneAt == 0) doneAt = k;
            fillStart = 1'b0;
            vramWr = (k >= stallAt && k < stallAt + stallN);
            vramWrAddr = 13'h0200;
            vramWrData = 8'h3C;
            if (k == injAt) begin
                fillStart = 1'b1;
                fillAddr = 13'h0500;
                fillLen = 14'd8;
                fillData = 8'h55;
            end
            if (k == rstAt) nrst = 1'b0;
            if (k == rstAt + 1) begin
                rstRd = vramRdData;
                rstBusy = fillBusy;
                rstDone = fillDone;
                nrst = 1'b1;
            end
            if (doneAt != 0 && k == doneAt + 1) break;
        end
        vramWr = 1'b0;
        fillStart = 1'b0;
    endtask

    int doneAt;
    int busyCnt;

    initial begin
        nrst = 1'b0;
        vramWr = 1'b0; vramWrAddr = '0; vramWrData = '0; vramRdAddr = '0;
        fillStart = 1'b0; fillAddr = '0; fillLen = '0; fillData = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rdData", {24'd0, vramRdData}, 32'h0);
        checkOutput("reset pipe rdData", {24'd0, rdDataP}, 32'h0);
        checkOutput("reset busy", {31'd0, fillBusy}, 32'h0);
        checkOutput("reset done", {31'd0, fillDone}, 32'h0);
        chkEn = 1;
        @(negedge clk);
        nrst = 1'b1;

        $display("[TB] clearing whole address space with the fill engine");
        startFill(13'h0000, 14'd8192, 8'h00);
        waitFill(0, 0, 0, 0, 8300, doneAt, busyCnt);
        checkOutput("clear done cycle", doneAt, 32'd8193);
        checkOutput("clear busy cycles", busyCnt, 32'd8193);

        $display("[TB] decode and mirroring");
        hostWrite(13'h1000, 8'hA5);
        hostWrite(13'h1400, 8'hC3);
        readCheck("mirror 0x1000", 13'h1000, 8'hC3);
        readCheck("mirror 0x1400", 13'h1400, 8'hC3);
        readCheck("mirror 0x1800", 13'h1800, 8'hC3);
        readCheck("mirror 0x1C00", 13'h1C00, 8'hC3);
        hostWrite(13'h0FFF, 8'h11);
        readCheck("lower 0x0FFF", 13'h0FFF, 8'h11);
        readCheck("lower 0x0000", 13'h0000, 8'h00);
        readCheck("lower 0x0400", 13'h0400, 8'h00);

        $display("[TB] read-first and read latency");
        applyStimulus(1'b1, 13'h0010, 8'h22, 13'h0010, 1'b0, 13'd0, 14'd0, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("read-first old", {24'd0, vramRdData}, 32'h00);
        readCheck("reread new", 13'h0010, 8'h22);
        checkOutput("pipe lags old", {24'd0, rdDataP}, 32'h00);
        @(posedge clk);
        #1;
        checkOutput("pipe new", {24'd0, rdDataP}, 32'h22);

        $display("[TB] basic fill");
        startFill(13'h0100, 14'd16, 8'h5A);
        waitFill(0, 0, 0, 0, 200, doneAt, busyCnt);
        checkOutput("basic done cycle", doneAt, 32'd17);
        checkOutput("basic busy cycles", busyCnt, 32'd17);
        readCheck("basic 0x0100", 13'h0100, 8'h5A);
        readCheck("basic 0x010F", 13'h010F, 8'h5A);
        readCheck("basic 0x00FF", 13'h00FF, 8'h00);
        readCheck("basic 0x0110", 13'h0110, 8'h00);

        $display("[TB] stalled fill");
        startFill(13'h0100, 14'd16, 8'h6B);
        waitFill(5, 3, 0, 0, 200, doneAt, busyCnt);
        checkOutput("stall done cycle", doneAt, 32'd20);
        checkOutput("stall busy cycles", busyCnt, 32'd20);
        readCheck("stall host word", 13'h0200, 8'h3C);
        for (int i = 0; i < 16; i++) begin
            readCheck("stall fill word", 13'h0100 + 13'(i), 8'h6B);
        end
        readCheck("stall 0x0110", 13'h0110, 8'h00);

        $display("[TB] wrapping fill and zero length");
        startFill(13'h1FFE, 14'd4, 8'h77);
        waitFill(0, 0, 0, 0, 200, doneAt, busyCnt);
        checkOutput("wrap done cycle", doneAt, 32'd5);
        readCheck("wrap 0x1FFE", 13'h1FFE, 8'h77);
        readCheck("wrap 0x1FFF", 13'h1FFF, 8'h77);
        readCheck("wrap 0x0000", 13'h0000, 8'h77);
        readCheck("wrap 0x0001", 13'h0001, 8'h77);
        readCheck("wrap 0x0002", 13'h0002, 8'h00);
        readCheck("wrap mirror 0x17FE", 13'h17FE, 8'h77);
        startFill(13'h0002, 14'd0, 8'hEE);
        waitFill(0, 0, 0, 0, 200, doneAt, busyCnt);
        checkOutput("zero-len done cycle", doneAt, 32'd1);
        checkOutput("zero-len busy cycles", busyCnt, 32'd1);
        readCheck("zero-len 0x0002", 13'h0002, 8'h00);

        $display("[TB] reset during fill");
        startFill(13'h0300, 14'd64, 8'h99);
        waitFill(0, 0, 0, 10, 80, doneAt, busyCnt);
        checkOutput("reset no done", doneAt, 32'd0);
        checkOutput("reset busy cycles", busyCnt, 32'd10);
        checkOutput("reset busy out", {31'd0, rstBusy}, 32'h0);
        checkOutput("reset done out", {31'd0, rstDone}, 32'h0);
        checkOutput("reset rd out", {24'd0, rstRd}, 32'h0);
        readCheck("reset 0x0308", 13'h0308, 8'h99);
        readCheck("reset 0x0309", 13'h0309, 8'h00);
        readCheck("reset 0x033F", 13'h033F, 8'h00);

        $display("[TB] ignored start and back-to-back fill");
        startFill(13'h0400, 14'd8, 8'h44);
        waitFill(0, 0, 3, 0, 200, doneAt, busyCnt);
        checkOutput("ignored done cycle", doneAt, 32'd9);
        startFill(13'h0600, 14'd2, 8'h66);
        waitFill(0, 0, 0, 0, 200, doneAt, busyCnt);
        checkOutput("b2b done cycle", doneAt, 32'd3);
        readCheck("ignored 0x0407", 13'h0407, 8'h44);
        readCheck("ignored 0x0408", 13'h0408, 8'h00);
        readCheck("ignored 0x0500", 13'h0500, 8'h00);
        readCheck("b2b 0x0601", 13'h0601, 8'h66);

        @(negedge clk);
        chkEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/vram_banked_fill.md
# vram_banked_fill

Parametrised two-bank video RAM with an independent display-side read port, a host-side write port and a built-in hardware fill engine. The upper address region mirrors a smaller upper bank, generalising the fixed 4 KB + 1 KB arrangement. The fill engine clears or paints VRAM regions without host byte-by-byte writes. The block sits between the host bus interface (write side) and the VGA pixel/character fetch logic (read side).

## Interface

**Parameters**

- `DATA_W`, 8: VRAM word width.
- `LOWER_AW`, 12: log2 of lower bank depth (4096 words).
- `UPPER_AW`, 10: log2 of upper bank depth (1024 words). Must satisfy `UPPER_AW <= LOWER_AW`.
- `RD_PIPE`, 0: extra read output register stages, 0 or 1.
- Derived: `ADDR_W = LOWER_AW + 1`.

**Ports** (clock and reset first)

- `clk`, in, 1: sole clock. All logic is on the rising edge.
- `nrst`, in, 1: synchronous, active-low reset.
- `vramWrAddr`, in, ADDR_W: host write address.
- `vramWrData`, in, DATA_W: host write data.
- `vramWr`, in, 1: 1 = write this cycle. Always accepted.
- `vramRdAddr`, in, ADDR_W: display read address.
- `vramRdData`, out, DATA_W: registered read data.
- `fillStart`, in, 1: one-cycle request to start a fill.
- `fillAddr`, in, ADDR_W: fill start address, sampled on `fillStart`.
- `fillLen`, in, ADDR_W+1: number of words to fill, sampled on `fillStart`.
- `fillData`, in, DATA_W: fill value, sampled on `fillStart`.
- `fillBusy`, out, 1: fill engine active.
- `fillDone`, out, 1: one-cycle pulse when a fill completes.

## Operation

**Address decode** (identical for read, write and fill)

- If `addr[ADDR_W-1] == 0`: lower bank, index `addr[LOWER_AW-1:0]`. The full lower bank is reachable.
- Otherwise: upper bank, index `addr[UPPER_AW-1:0]`. The upper region mirrors the upper bank `2^(LOWER_AW-UPPER_AW)` times.
- Memory contents are not reset. Each bank must infer as block RAM: one write port and one read port per bank.

**Read**

- Both banks are read every cycle at the decoded index.
- The output is selected by `vramRdAddr[ADDR_W-1]` registered alongside the read.
- Read-during-write to the same word returns the old data (read-first).

**Fill FSM**

- States: IDLE, FILL, DONE.
- IDLE: on `fillStart`, latch `fillAddr`, `fillData` and `fillLen` into `curAddr`, `val` and `remaining`.
  - If `fillLen == 0`, go to DONE.
  - Otherwise go to FILL.
- FILL: each cycle in which `vramWr == 0`, write `val` at `curAddr`, then `curAddr <= curAddr + 1` (mod 2^ADDR_W) and `remaining <= remaining - 1`.
  - When `remaining` reaches 0 after a write, go to DONE.
  - A cycle with `vramWr == 1` stalls the fill. The host write proceeds and no fill word is lost or skipped.
- DONE: assert `fillDone` for one cycle, then return to IDLE.
- `fillBusy = 1` in FILL and DONE.
- `fillStart` in FILL or DONE is ignored; there is no queueing.
- Fills wrap past the top of the address space to 0. A fill longer than the physical storage simply rewrites mirrored or wrapped words.

## Timing

**Reset values:** `vramRdData = 0`, `fillBusy = 0`, `fillDone = 0`, FSM in IDLE. Reset during FILL aborts the fill immediately: no further writes and no `fillDone`.

**Read latency:** 1 + `RD_PIPE` cycles from `vramRdAddr` to `vramRdData`.

**Fill timing**

- `fillStart` at cycle T: `fillBusy` rises at T+1 and the first fill write commits at the T+1 edge.
- An unstalled fill of N words writes during T+1..T+N, pulses `fillDone` at T+N+1, and deasserts `fillBusy` at T+N+2.
- Each host-write stall adds exactly one cycle.
- With `fillLen == 0`, `fillDone` pulses at T+1 and no writes occur.
- Host write and fill write never commit in the same cycle.
- Host writes commit on the edge after `vramWr` is asserted.

**Back-to-back fills:** `fillStart` asserted in the cycle after `fillDone` (IDLE) is accepted.

## Test plan

- **Decode/mirroring:** write 0xA5 to 0x1000, 0xC3 to 0x1400, read 0x1000, 0x1400, 0x1800, 0x1C00. Required: 0xC3 for all four (mirrored). Write 0x11 to 0x0FFF and read it back: 0x11. Lower bank unaffected.
- **Read latency / read-first:** with `RD_PIPE=0`, write 0x22 to 0x0010 while reading 0x0010 in the same cycle. Required: old value on the next cycle, 0x22 when re-read one cycle later. With `RD_PIPE=1`, data appears one cycle later than with `RD_PIPE=0`.
- **Basic fill:** `fillStart` with addr 0x0100, len 16, data 0x5A. Required: `fillBusy` for 17 cycles, `fillDone` pulse at T+17, 0x0100..0x010F = 0x5A, 0x00FF and 0x0110 unchanged.
- **Stall:** same fill with `vramWr` asserted for 3 cycles mid-fill to 0x0200. Required: host data at 0x0200, all 16 fill words written, `fillDone` at T+20.
- **Wrap and zero length:** fill addr 0x1FFE, len 4, data 0x77. Required: words 0x1FFE, 0x1FFF, 0x0000, 0x0001 written. Fill with len 0 gives `fillDone` at T+1 and no memory change.
- **Reset and ignored start:** assert `nrst` low for 1 cycle mid-fill of 64 words. Required: outputs 0, no `fillDone`, no writes after reset. Separately, `fillStart` during a busy fill is ignored: only the first fill's region is written.
